// File: rtl/clk_divider_pkg.sv
// Shared constants and elaboration helpers for the integer clock divider.
`timescale 1ns/1ps
package clk_divider_pkg;

  localparam int DEFAULT_DIVISOR = 10;
  localparam int MAX_DIVISOR     = 65535;

  // Counter width: enough bits for 0..divisor-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int divisor);
    if (divisor <= 2) return 1;
    return unsigned'($clog2(divisor));
  endfunction

  // First count value at which the registered phase goes high.
  function automatic int unsigned hi_start(input int divisor);
    if (divisor % 2 == 0) return unsigned'(divisor / 2);
    return unsigned'((divisor + 1) / 2);
  endfunction

endpackage

// File: rtl/clk_divider.sv
// Integer clock divider with 50% duty for even and odd ratios.
// Odd ratios stretch the high phase by half a cycle with a falling-edge register.
`timescale 1ns/1ps
module clk_divider
  import clk_divider_pkg::*;
#(
  parameter int DIVISOR = DEFAULT_DIVISOR
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk
);

  localparam int unsigned CNT_W    = cnt_width(DIVISOR);
  localparam int unsigned HI_START = hi_start(DIVISOR);

  logic [CNT_W-1:0] cnt;

  if (DIVISOR < 1 || DIVISOR > MAX_DIVISOR) begin : g_bad_divisor
    $error("clk_divider: DIVISOR %0d outside 1..%0d", DIVISOR, MAX_DIVISOR);
  end

  if (DIVISOR == 1) begin : g_bypass
    // Ratio 1 passes the source through, gated low while in reset.
    assign cnt = '0;
    assign clk = clk_in & reset;
  end else begin : g_div
    logic [CNT_W-1:0] cnt_next;
    logic             p_next;
    logic             p;

    always_comb begin
      cnt_next = cnt + CNT_W'(1);
      if (cnt == CNT_W'(DIVISOR - 1)) cnt_next = '0;
      p_next = (cnt_next >= CNT_W'(HI_START));
    end

    always_ff @(posedge clk_in or negedge reset) begin
      if (!reset) begin
        cnt <= '0;
        p   <= 1'b0;
      end else begin
        cnt <= cnt_next;
        p   <= p_next;
      end
    end

    if (DIVISOR % 2 == 0) begin : g_even
      assign clk = p;
    end else begin : g_odd
      // n trails p by half a cycle; p and n never switch on the same edge.
      logic n;

      always_ff @(negedge clk_in or negedge reset) begin
        if (!reset) n <= 1'b0;
        else        n <= p;
      end

      assign clk = p | n;
    end
  end

endmodule

// File: tb/tb_clk_divider.sv
// Directed bench for clk_divider at ratios 10, 5, 2 and 1 sharing one source and reset.
`timescale 1ns/1ps
module tb_clk_divider;

  logic clk_in = 1'b0;
  logic reset  = 1'b1;
  logic clk10, clk5, clk2, clk1;

  int checks = 0;
  int errors = 0;

  real r10[$], f10[$], r5[$], f5[$], r2[$], f2[$];

  clk_divider #(.DIVISOR(10)) u_div10 (.clk_in(clk_in), .reset(reset), .clk(clk10));
  clk_divider #(.DIVISOR(5))  u_div5  (.clk_in(clk_in), .reset(reset), .clk(clk5));
  clk_divider #(.DIVISOR(2))  u_div2  (.clk_in(clk_in), .reset(reset), .clk(clk2));
  clk_divider #(.DIVISOR(1))  u_div1  (.clk_in(clk_in), .reset(reset), .clk(clk1));

  // 2 ns source: rising edges at odd ns, falling edges at even ns.
  always #1 clk_in = ~clk_in;

  always @(posedge clk10) r10.push_back($realtime);
  always @(negedge clk10) f10.push_back($realtime);
  always @(posedge clk5)  r5.push_back($realtime);
  always @(negedge clk5)  f5.push_back($realtime);
  always @(posedge clk2)  r2.push_back($realtime);
  always @(negedge clk2)  f2.push_back($realtime);

  task automatic wait_until(input real t);
    if (t > $realtime) #(t - $realtime);
  endtask

  task automatic clear_edges();
    r10.delete(); f10.delete(); r5.delete(); f5.delete(); r2.delete(); f2.delete();
  endtask

  task automatic test_reset();
    real pts[3] = '{5.5, 12.5, 19.5};
    #0.2 reset = 1'b0;
    foreach (pts[i]) begin
      wait_until(pts[i]);
      checks++;
      if ({clk10, clk5, clk2, clk1} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outputs@%0.1f: got %b expected 0000", pts[i], {clk10, clk5, clk2, clk1});
      end
    end
    checks++;
    if (u_div10.cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", u_div10.cnt);
    end
    checks++;
    if (r10.size() + r5.size() + r2.size() != 0) begin
      errors++;
      $display("FAIL reset_no_rise: got %0d rising edges expected 0", r10.size() + r5.size() + r2.size());
    end
    wait_until(20.5);
    clear_edges();
    reset = 1'b1;
  endtask

  task automatic test_even();
    real exp_r[2] = '{29.0, 49.0};
    real exp_f[2] = '{39.0, 59.0};
    wait_until(60.5);
    checks++;
    if (r10.size() != 2 || f10.size() != 2) begin
      errors++;
      $display("FAIL div10_edge_count: got %0d/%0d expected 2/2", r10.size(), f10.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (r10[i] != exp_r[i] || f10[i] != exp_f[i]) begin
          errors++;
          $display("FAIL div10_edge%0d: got rise %0.1f fall %0.1f expected %0.1f %0.1f",
                   i, r10[i], f10[i], exp_r[i], exp_f[i]);
        end
      end
    end
  endtask

  task automatic test_odd();
    real exp_r[4] = '{25.0, 35.0, 45.0, 55.0};
    real exp_f[4] = '{30.0, 40.0, 50.0, 60.0};
    wait_until(60.5);
    checks++;
    if (r5.size() != 4 || f5.size() != 4) begin
      errors++;
      $display("FAIL div5_edge_count: got %0d/%0d expected 4/4", r5.size(), f5.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (r5[i] != exp_r[i] || f5[i] != exp_f[i]) begin
          errors++;
          $display("FAIL div5_edge%0d: got rise %0.1f fall %0.1f expected %0.1f %0.1f",
                   i, r5[i], f5[i], exp_r[i], exp_f[i]);
        end
      end
    end
  endtask

  task automatic test_div2();
    int bad = 0;
    wait_until(60.5);
    checks++;
    if (r2.size() != 10 || f2.size() != 10) begin
      errors++;
      $display("FAIL div2_edge_count: got %0d/%0d expected 10/10", r2.size(), f2.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        if (r2[i] != 21.0 + 4.0 * i || f2[i] != 23.0 + 4.0 * i) bad++;
      end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL div2_timing: got %0d misplaced edges expected 0 (first rise %0.1f expected 21.0)",
                 bad, r2[0]);
      end
    end
  endtask

  task automatic test_div1();
    logic exp;
    wait_until(60.75);
    for (int i = 0; i < 8; i++) begin
      exp = 1'(((i + 1) >> 1) & 1);
      checks++;
      if (clk1 !== exp) begin
        errors++;
        $display("FAIL div1_follow@%0.2f: got %b expected %b", $realtime, clk1, exp);
      end
      #0.5;
    end
  endtask

  task automatic test_reset_mid();
    wait_until(72.3);
    checks++;
    if (clk10 !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_high: got %b expected 1", clk10);
    end
    reset = 1'b0;
    #0.1;
    checks++;
    if ({clk10, clk5, clk2, clk1} !== 4'b0000 || u_div10.cnt !== 4'd0) begin
      errors++;
      $display("FAIL mid_abort: got clks %b cnt %0d expected 0000 cnt 0",
               {clk10, clk5, clk2, clk1}, u_div10.cnt);
    end
    clear_edges();
    wait_until(82.3);
    checks++;
    if (r10.size() + r5.size() + r2.size() != 0 || clk10 !== 1'b0) begin
      errors++;
      $display("FAIL mid_hold: got %0d rises clk10=%b expected 0 rises clk10=0",
               r10.size() + r5.size() + r2.size(), clk10);
    end
    reset = 1'b1;
    wait_until(102.5);
    checks++;
    if (r10.size() != 1 || f10.size() != 1 || r5.size() != 2 || f5.size() != 2 || r2.size() == 0) begin
      errors++;
      $display("FAIL mid_restart_count: got r10=%0d f10=%0d r5=%0d f5=%0d r2=%0d expected 1 1 2 2 >0",
               r10.size(), f10.size(), r5.size(), f5.size(), r2.size());
    end else begin
      checks++;
      if (r10[0] != 91.0 || f10[0] != 101.0) begin
        errors++;
        $display("FAIL mid_restart_div10: got rise %0.1f fall %0.1f expected 91.0 101.0", r10[0], f10[0]);
      end
      checks++;
      if (r5[0] != 87.0 || f5[0] != 92.0) begin
        errors++;
        $display("FAIL mid_restart_div5: got rise %0.1f fall %0.1f expected 87.0 92.0", r5[0], f5[0]);
      end
      checks++;
      if (r2[0] != 83.0) begin
        errors++;
        $display("FAIL mid_restart_div2: got rise %0.1f expected 83.0", r2[0]);
      end
    end
  endtask

  task automatic test_long_run();
    int bad10 = 0;
    int bad5  = 0;
    clear_edges();
    wait_until(1102.5);
    checks++;
    if (r10.size() != 50 || f10.size() != 50) begin
      errors++;
      $display("FAIL long_div10_periods: got %0d/%0d expected 50/50", r10.size(), f10.size());
    end else begin
      for (int i = 0; i < 50; i++) begin
        if (f10[i] - r10[i] != 10.0) bad10++;
        if (i < 49 && r10[i+1] - f10[i] != 10.0) bad10++;
      end
      checks++;
      if (bad10 != 0 || r10[0] != 111.0) begin
        errors++;
        $display("FAIL long_div10_widths: got %0d bad phases first rise %0.1f expected 0 and 111.0",
                 bad10, r10[0]);
      end
    end
    checks++;
    if (r5.size() != 100 || f5.size() != 100) begin
      errors++;
      $display("FAIL long_div5_periods: got %0d/%0d expected 100/100", r5.size(), f5.size());
    end else begin
      for (int i = 0; i < 100; i++) begin
        if (f5[i] - r5[i] != 5.0) bad5++;
        if (i < 99 && r5[i+1] - f5[i] != 5.0) bad5++;
      end
      checks++;
      if (bad5 != 0) begin
        errors++;
        $display("FAIL long_div5_widths: got %0d bad phases expected 0", bad5);
      end
    end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_div2();
    test_div1();
    test_reset_mid();
    test_long_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
